board_monitor: RTL and testbench

//   Board-level run/step controller and display engine for the CPU. Generates a one-cycle
//   CPU clock-enable pulse from a free-running divider (run) or a debounced button (step).

---
 rtl/board_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_board_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/board_monitor.sv
// board_monitor: run/step CPU clock-enable generator, display-source selector,
// iterative binary-to-BCD 7-segment driver and status LEDs.
// Optional feature macro: BOARD_MONITOR_LZB_EN (leading-zero blanking).
module board_monitor #(
    parameter int unsigned DIVISOR         = 50_000_000,
    parameter int unsigned ADDR_WIDTH      = 6,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run_sw,
    input  logic                    step_btn,
    input  logic                    mode_btn,
    input  logic [ADDR_WIDTH-1:0]   pc,
    input  logic [ADDR_WIDTH-1:0]   sp,
    input  logic [DATA_WIDTH-1:0]   out,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    cpu_clk_en,
    output logic                    busy,
    output logic [9:0]              led,
    output logic [7*DIGITS-1:0]     hex
);

    localparam int unsigned W     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned BW    = 4 * DIGITS;
    localparam int unsigned DIV_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CNT_W = $clog2(W + 1);

`ifdef BOARD_MONITOR_LZB_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              run_sync;
    logic                    run_s;
    logic [1:0]              btn_meta, btn_s, db_lvl, db_prev, press_c;
    logic [1:0][DB_W-1:0]    db_cnt;
    logic [DIV_W-1:0]        div_cnt, div_nxt;
    logic                    en_nxt, heartbeat;
    logic [1:0]              sel, sel_lat, last_sel;
    logic [W-1:0]            src, shreg, val_lat, last_val;
    logic                    last_vld;
    logic [BW-1:0]           bcd, bcd_adj;
    logic [CNT_W-1:0]        bit_cnt;
    logic [7*DIGITS-1:0]     hex_nxt;

    assign run_s   = run_sync[1];
    assign press_c = db_lvl & ~db_prev;

    // Synchronise the switch and buttons, then debounce buttons (index 0 = step, 1 = mode)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync <= '0;
            btn_meta <= '0;
            btn_s    <= '0;
            db_lvl   <= '0;
            db_prev  <= '0;
            db_cnt   <= '0;
        end else begin
            run_sync <= {run_sync[0], run_sw};
            btn_meta <= {mode_btn, step_btn};
            btn_s    <= btn_meta;
            db_prev  <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (btn_s[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_lvl[i] <= btn_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next divider count and clock-enable: free-running in run mode, step press otherwise
    always_comb begin
        div_nxt = '0;
        en_nxt  = 1'b0;
        if (run_s) begin
            div_nxt = (div_cnt == DIV_W'(DIVISOR - 1)) ? '0 : div_cnt + 1'b1;
            en_nxt  = (div_nxt == DIV_W'(DIVISOR - 1));
        end else begin
            en_nxt  = press_c[0];
        end
    end

    // Divider, clock-enable pulse, heartbeat, display-source select and LED register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            cpu_clk_en <= 1'b0;
            heartbeat  <= 1'b0;
            sel        <= '0;
            led        <= '0;
        end else begin
            div_cnt    <= div_nxt;
            cpu_clk_en <= en_nxt;
            heartbeat  <= heartbeat ^ en_nxt;
            if (press_c[1]) sel <= sel + 2'd1;
            led        <= {heartbeat, run_s, sel, busy, out[4:0]};
        end
    end

    // Zero-extended display source
    always_comb begin
        case (sel)
            2'd0:    src = W'(pc);
            2'd1:    src = W'(sp);
            2'd2:    src = W'(out);
            default: src = W'(mem_addr);
        endcase
    end

    // Conversion FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Conversion FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!last_vld || src != last_val || sel != last_sel) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (bit_cnt == CNT_W'(W - 1)) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to each BCD nibble >= 5 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Segment image from the finished BCD: dashes on overflow, optional leading blanks
    always_comb begin
        logic lead;
        hex_nxt = '1;
        lead    = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (64'(val_lat) >= LIMIT) begin
                hex_nxt[7*i +: 7] = 7'b0111111;
            end else if (LZB_EN && lead && bcd[4*i +: 4] == 4'd0 && i != 0) begin
                hex_nxt[7*i +: 7] = 7'b1111111;
            end else begin
                hex_nxt[7*i +: 7] = seg7(bcd[4*i +: 4]);
                lead = 1'b0;
            end
        end
    end

    // Conversion datapath, busy flag and display register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            val_lat  <= '0;
            sel_lat  <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            last_val <= '0;
            last_sel <= '0;
            last_vld <= 1'b0;
            busy     <= 1'b0;
            hex      <= '1;
        end else begin
            busy <= (state_nxt != S_IDLE);
            case (state)
                S_LOAD: begin
                    shreg   <= src;
                    val_lat <= src;
                    sel_lat <= sel;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                S_SHIFT: begin
                    bcd     <= {bcd_adj[BW-2:0], shreg[W-1]};
                    shreg   <= {shreg[W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_DONE: begin
                    hex      <= hex_nxt;
                    last_val <= val_lat;
                    last_sel <= sel_lat;
                    last_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_monitor.sv
// Scoreboard bench for board_monitor: expected hex images are queued by the
// stimulus and popped by a monitor at each end of conversion (busy falling).
module tb_board_monitor;

    localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000, BL = 7'b1111111, DS = 7'b0111111;

`ifdef BOARD_MONITOR_LZB_EN
    localparam logic [27:0] H0042 = {BL, BL, S4, S2};
    localparam logic [27:0] H0007 = {BL, BL, BL, S7};
    localparam logic [27:0] H0063 = {BL, BL, S6, S3};
`else
    localparam logic [27:0] H0042 = {S0, S0, S4, S2};
    localparam logic [27:0] H0007 = {S0, S0, S0, S7};
    localparam logic [27:0] H0063 = {S0, S0, S6, S3};
`endif
    localparam logic [27:0] HDASH = {DS, DS, DS, DS};
    localparam logic [27:0] H9999 = {S9, S9, S9, S9};
    localparam int CONV_CYCLES = 18;

    logic        clk = 1'b0;
    logic        rst_n, run_sw, step_btn, mode_btn;
    logic [5:0]  pc, sp, mem_addr;
    logic [15:0] out_r;
    logic        cpu_clk_en, busy;
    logic [9:0]  led;
    logic [27:0] hex;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int en_count = 0;
    int pulse_q[$];
    logic [27:0] exp_q[$];

    board_monitor #(
        .DIVISOR(4), .ADDR_WIDTH(6), .DATA_WIDTH(16), .DIGITS(4), .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn), .mode_btn(mode_btn),
        .pc(pc), .sp(sp), .out(out_r), .mem_addr(mem_addr),
        .cpu_clk_en(cpu_clk_en), .busy(busy), .led(led), .hex(hex)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Clock-enable pulse recorder
    always @(negedge clk) begin
        if (rst_n && cpu_clk_en) begin
            en_count++;
            pulse_q.push_back(cyc);
        end
    end

    // Conversion monitor: pops the scoreboard whenever busy falls
    logic busy_prev = 1'b0;
    int   busy_len  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy) busy_len++;
            if (busy_prev && !busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL conv_unexpected: got hex %h with no expectation queued", hex);
                end else begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    if (hex !== e) begin
                        errors++;
                        $display("FAIL conv_hex: got %h expected %h", hex, e);
                    end
                end
                checks++;
                if (busy_len != CONV_CYCLES) begin
                    errors++;
                    $display("FAIL conv_busy_len: got %0d expected %0d", busy_len, CONV_CYCLES);
                end
                busy_len = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic press_mode();
        mode_btn = 1'b1;
        repeat (8) @(negedge clk);
        mode_btn = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    initial begin
        int t0, base;
        rst_n = 1'b0; run_sw = 1'b1; step_btn = 1'b0; mode_btn = 1'b0;
        pc = 6'd42; sp = 6'd7; mem_addr = 6'd63; out_r = 16'd12345;
        repeat (3) @(negedge clk);
        check("rst_en",   32'(cpu_clk_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hex",  32'(hex), 32'h0FFF_FFFF);
        check("rst_led",  32'(led), 32'd0);

        // Run mode pulses and initial conversion of pc
        exp_q.push_back(H0042);
        t0 = cyc;
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        if (pulse_q.size() >= 3) begin
            check("first_pulse_window", 32'((pulse_q[0] - t0) >= 4 && (pulse_q[0] - t0) <= 6), 32'd1);
            check("pulse_gap1", 32'(pulse_q[1] - pulse_q[0]), 32'd4);
            check("pulse_gap2", 32'(pulse_q[2] - pulse_q[1]), 32'd4);
        end else begin
            check("pulse_count", 32'(pulse_q.size()), 32'd3);
        end

        // Step mode: heartbeat parity, glitches, one held press
        run_sw = 1'b0;
        repeat (10) @(negedge clk);
        check("heartbeat", 32'(led[9]), 32'(en_count % 2));
        check("led_run", 32'(led[8]), 32'd0);
        base = en_count;
        repeat (2) begin
            step_btn = 1'b1; @(negedge clk);
            step_btn = 1'b0; repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("glitch_no_pulse", 32'(en_count), 32'(base));
        step_btn = 1'b1;
        repeat (10) @(negedge clk);
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("step_one_pulse", 32'(en_count), 32'(base + 1));

        // Display-source cycling
        exp_q.push_back(H0007); press_mode(); check("sel1", 32'(led[7:6]), 32'd1);
        exp_q.push_back(HDASH); press_mode(); check("sel2", 32'(led[7:6]), 32'd2);
        check("led_out_low", 32'(led[4:0]), 32'd25);
        exp_q.push_back(H0063); press_mode(); check("sel3", 32'(led[7:6]), 32'd3);
        exp_q.push_back(H0042); press_mode(); check("sel_wrap", 32'(led[7:6]), 32'd0);
        exp_q.push_back(H0007); press_mode();
        exp_q.push_back(HDASH); press_mode();
        exp_q.push_back(H9999);
        out_r = 16'd9999;
        repeat (30) @(negedge clk);

        // Reset in the middle of a conversion
        out_r = 16'd100;
        repeat (5) @(negedge clk);
        check("led_busy", 32'(led[5]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hex",  32'(hex), 32'h0FFF_FFFF);
        check("midrst_led",  32'(led), 32'd0);
        exp_q.push_back(H0042);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
